// File: rtl/wbu_commit_stage.sv
// wbu_commit_stage: write-back / commit stage of the multi-cycle core.
// Latches one executed bundle per handshake. Waits for load data when the
// bundle selects it. Drives the register-file write port for one COMMIT
// cycle, owns the architectural PC, and raises a one-cycle retire pulse.
// A load that waits too long parks the stage in a sticky error state,
// which only reset can clear.
// Optional trace outputs (commit_pc, commit_next_pc, commit_cnt) are built
// only when the macro WBU_COMMIT_TRACE_EN is defined.
module wbu_commit_stage #(
   parameter logic [31:0] RESET_PC     = 32'h8000_0000,
   parameter int unsigned LOAD_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        jal,
   input  logic        branch,
   input  logic        brlt,
   input  logic [1:0]  regS,
   input  logic        RegW,
   input  logic        PCx1,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_imm,
   input  logic [31:0] in_alu_res,
   input  logic        in_zero,
   input  logic        in_lt,
   input  logic [4:0]  in_rd,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata,
   output logic        rf_wen,
   output logic [4:0]  rf_waddr,
   output logic [31:0] rf_wdata,
   output logic [31:0] pc,
   output logic        commit_valid,
   output logic        err
`ifdef WBU_COMMIT_TRACE_EN
   ,
   output logic [31:0] commit_pc,
   output logic [31:0] commit_next_pc,
   output logic [63:0] commit_cnt
`endif
);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_WAIT_MEM = 2'd1,
      S_COMMIT   = 2'd2,
      S_ERR      = 2'd3
   } state_t;

   localparam logic [7:0] TIMEOUT_LIM = 8'(LOAD_TIMEOUT);

   state_t             state, state_nxt;
   logic [7:0]         cnt_p0, cnt_nxt;
   logic               accept;

   // Bundle registers captured at the accept edge
   logic               jal_p0, branch_p0, brlt_p0, pcx1_p0, regw_p0;
   logic               zero_p0, lt_p0;
   logic [1:0]         regs_p0;
   logic [4:0]         rd_p0;
   logic [31:0]        pc_in_p0, alu_p0;
   logic signed [31:0] imm_p0;
   logic [31:0]        ldata_p0;

   logic [31:0]        pc_plus4, pc_plus_imm, next_pc, wb_data;
   logic               take_target;

   assign accept = in_valid && in_ready;

   // Control state: FSM state, load-wait counter and architectural PC
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= S_IDLE;
         cnt_p0 <= 8'd0;
         pc     <= RESET_PC;
      end else begin
         state  <= state_nxt;
         cnt_p0 <= cnt_nxt;
         if (state == S_COMMIT) begin
            pc <= next_pc;
         end
      end
   end

   // Next-state logic and handshake / status outputs
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt_p0;
      in_ready     = 1'b0;
      commit_valid = 1'b0;
      err          = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               cnt_nxt   = 8'd0;
               state_nxt = (regS == 2'd1) ? S_WAIT_MEM : S_COMMIT;
            end
         end
         S_WAIT_MEM: begin
            // Data arriving on the limit cycle still wins over the timeout
            if (mem_rvalid) begin
               cnt_nxt   = 8'd0;
               state_nxt = S_COMMIT;
            end else begin
               cnt_nxt = 8'(cnt_p0 + 8'd1);
               if (cnt_nxt == TIMEOUT_LIM) begin
                  state_nxt = S_ERR;
               end
            end
         end
         S_COMMIT: begin
            commit_valid = 1'b1;
            state_nxt    = S_IDLE;
         end
         S_ERR: begin
            err = 1'b1;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Capture the executed bundle on the accept handshake
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         jal_p0    <= 1'b0;
         branch_p0 <= 1'b0;
         brlt_p0   <= 1'b0;
         pcx1_p0   <= 1'b0;
         regw_p0   <= 1'b0;
         zero_p0   <= 1'b0;
         lt_p0     <= 1'b0;
         regs_p0   <= 2'd0;
         rd_p0     <= 5'd0;
         pc_in_p0  <= 32'd0;
         alu_p0    <= 32'd0;
         imm_p0    <= 32'sd0;
      end else if (accept) begin
         jal_p0    <= jal;
         branch_p0 <= branch;
         brlt_p0   <= brlt;
         pcx1_p0   <= PCx1;
         regw_p0   <= RegW;
         zero_p0   <= in_zero;
         lt_p0     <= in_lt;
         regs_p0   <= regS;
         rd_p0     <= in_rd;
         pc_in_p0  <= in_pc;
         alu_p0    <= in_alu_res;
         imm_p0    <= $signed(in_imm);
      end
   end

   // Capture load data when it arrives during the wait
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ldata_p0 <= 32'd0;
      end else if ((state == S_WAIT_MEM) && mem_rvalid) begin
         ldata_p0 <= mem_rdata;
      end
   end

   // Next PC and write-back data from the latched bundle (32-bit wrap)
   always_comb begin
      pc_plus4    = pc_in_p0 + 32'd4;
      pc_plus_imm = pc_in_p0 + $unsigned(imm_p0);
      take_target = jal_p0 || (branch_p0 && zero_p0) || (brlt_p0 && lt_p0);
      if (pcx1_p0) begin
         next_pc = {alu_p0[31:1], 1'b0};
      end else if (take_target) begin
         next_pc = pc_plus_imm;
      end else begin
         next_pc = pc_plus4;
      end
      case (regs_p0)
         2'd0:    wb_data = alu_p0;
         2'd1:    wb_data = ldata_p0;
         2'd2:    wb_data = pc_plus4;
         default: wb_data = pc_plus_imm;
      endcase
   end

   // Register-file write port is live only in the COMMIT cycle
   always_comb begin
      rf_wen   = 1'b0;
      rf_waddr = 5'd0;
      rf_wdata = 32'd0;
      if (state == S_COMMIT) begin
         rf_wen   = regw_p0 && (rd_p0 != 5'd0);
         rf_waddr = rd_p0;
         rf_wdata = wb_data;
      end
   end

`ifdef WBU_COMMIT_TRACE_EN
   // Retired-instruction counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         commit_cnt <= 64'd0;
      end else if (commit_valid) begin
         commit_cnt <= commit_cnt + 64'd1;
      end
   end

   // Trace PCs are meaningful only alongside the retire pulse
   always_comb begin
      commit_pc      = 32'd0;
      commit_next_pc = 32'd0;
      if (commit_valid) begin
         commit_pc      = pc_in_p0;
         commit_next_pc = next_pc;
      end
   end
`endif

endmodule

// File: tb/tb_wbu_commit_stage.sv
// Testbench for wbu_commit_stage: randomized bundles plus directed corner
// cases, checked by a scoreboard fed from a behavioural reference model.
`timescale 1ns/1ps
module tb_wbu_commit_stage;

   localparam logic [31:0] RESET_PC = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        jal = 1'b0, branch = 1'b0, brlt = 1'b0, RegW = 1'b0, PCx1 = 1'b0;
   logic [1:0]  regS = 2'd0;
   logic [31:0] in_pc = '0, in_imm = '0, in_alu_res = '0;
   logic        in_zero = 1'b0, in_lt = 1'b0;
   logic [4:0]  in_rd = '0;
   logic        mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;
   logic        rf_wen;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata;
   logic [31:0] pc;
   logic        commit_valid;
   logic        err;
`ifdef WBU_COMMIT_TRACE_EN
   logic [31:0] commit_pc, commit_next_pc;
   logic [63:0] commit_cnt;
`endif

   always #5 clk = ~clk;

   wbu_commit_stage #(.RESET_PC(RESET_PC), .LOAD_TIMEOUT(255)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .jal(jal), .branch(branch), .brlt(brlt), .regS(regS), .RegW(RegW),
      .PCx1(PCx1), .in_pc(in_pc), .in_imm(in_imm), .in_alu_res(in_alu_res),
      .in_zero(in_zero), .in_lt(in_lt), .in_rd(in_rd),
      .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
      .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .pc(pc),
      .commit_valid(commit_valid), .err(err)
`ifdef WBU_COMMIT_TRACE_EN
      , .commit_pc(commit_pc), .commit_next_pc(commit_next_pc), .commit_cnt(commit_cnt)
`endif
   );

   typedef struct {
      logic [31:0] pc, imm, alu;
      logic [1:0]  regs;
      logic        regw, jal, branch, brlt, pcx1, zero, lt;
      logic [4:0]  rd;
   } bundle_t;

   typedef struct {
      logic        wen;
      logic [4:0]  waddr;
      logic [31:0] wdata;
      logic [31:0] npc;
      logic [31:0] ipc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   logic [31:0] exp_pc = RESET_PC;
   logic [63:0] exp_cnt = '0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference model: architectural effect of retiring one bundle
   function automatic exp_t model(input bundle_t b, input logic [31:0] ld);
      exp_t e;
      logic [31:0] seq, tgt;
      seq     = b.pc + 32'd4;
      tgt     = b.pc + b.imm;
      e.wen   = b.regw && (b.rd != 5'd0);
      e.waddr = b.rd;
      e.ipc   = b.pc;
      case (b.regs)
         2'd0:    e.wdata = b.alu;
         2'd1:    e.wdata = ld;
         2'd2:    e.wdata = seq;
         default: e.wdata = tgt;
      endcase
      if (b.pcx1)                                                e.npc = b.alu & 32'hFFFF_FFFE;
      else if (b.jal || (b.branch && b.zero) || (b.brlt && b.lt)) e.npc = tgt;
      else                                                       e.npc = seq;
      return e;
   endfunction

   function automatic bundle_t mk(input logic [31:0] p, input logic [31:0] imm,
                                  input logic [31:0] alu, input logic [1:0] rs,
                                  input logic rw, input logic [4:0] rd);
      bundle_t b;
      b.pc = p; b.imm = imm; b.alu = alu; b.regs = rs; b.regw = rw; b.rd = rd;
      b.jal = 1'b0; b.branch = 1'b0; b.brlt = 1'b0; b.pcx1 = 1'b0;
      b.zero = 1'b0; b.lt = 1'b0;
      return b;
   endfunction

   // Monitor: PC tracking every cycle, scoreboard pop on each retire pulse
   always @(negedge clk) begin
      if (mon_en) begin
         chk("pc", pc, exp_pc);
         if (commit_valid) begin
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_commit: actual waddr=%0h wdata=%0h required no retire", rf_waddr, rf_wdata);
            end else begin
               mon_e = sbq.pop_front();
               chk("rf_wen", rf_wen, mon_e.wen);
               chk("rf_waddr", rf_waddr, mon_e.waddr);
               chk("rf_wdata", rf_wdata, mon_e.wdata);
               chk("ready_in_commit", in_ready, 1'b0);
`ifdef WBU_COMMIT_TRACE_EN
               chk("commit_pc", commit_pc, mon_e.ipc);
               chk("commit_next_pc", commit_next_pc, mon_e.npc);
               chk("commit_cnt", commit_cnt, exp_cnt);
               exp_cnt = exp_cnt + 64'd1;
`endif
               exp_pc = mon_e.npc;
            end
         end else begin
            chk("rf_wen_idle", rf_wen, 1'b0);
         end
      end
   end

   // Issue one bundle; delay>=0 drives load data after that many wait cycles
   task automatic send(input bundle_t b, input int delay, input logic [31:0] ld, input bit expect_commit);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ready_wait", in_ready, 1'b1);
      if (!in_ready) return;
      mem_rvalid = 1'($urandom_range(0, 1));
      mem_rdata  = $urandom;
      in_pc = b.pc; in_imm = b.imm; in_alu_res = b.alu; regS = b.regs;
      RegW = b.regw; jal = b.jal; branch = b.branch; brlt = b.brlt;
      PCx1 = b.pcx1; in_zero = b.zero; in_lt = b.lt; in_rd = b.rd;
      in_valid = 1'b1;
      if (expect_commit) sbq.push_back(model(b, ld));
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      mem_rvalid = 1'b0;
      in_pc = $urandom; in_imm = $urandom; in_alu_res = $urandom;
      regS = 2'($urandom_range(0, 3)); RegW = 1'($urandom_range(0, 1));
      PCx1 = 1'($urandom_range(0, 1)); jal = 1'($urandom_range(0, 1));
      in_rd = 5'($urandom_range(0, 31));
      if (b.regs == 2'd1 && delay >= 0) begin
         repeat (delay) begin
            @(negedge clk);
            chk("ready_wait_mem", in_ready, 1'b0);
         end
         @(negedge clk);
         mem_rvalid = 1'b1;
         mem_rdata  = ld;
         @(posedge clk);
         #1;
         mem_rvalid = 1'b0;
         mem_rdata  = $urandom;
      end
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      #2;
      chk("rst_pc", pc, RESET_PC);
      chk("rst_err", err, 1'b0);
      chk("rst_in_ready", in_ready, 1'b1);
      chk("rst_rf_wen", rf_wen, 1'b0);
      chk("rst_rf_waddr", rf_waddr, 5'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      chk("rst_commit_valid", commit_valid, 1'b0);
`ifdef WBU_COMMIT_TRACE_EN
      chk("rst_commit_cnt", commit_cnt, 64'd0);
`endif
      sbq.delete();
      exp_pc  = RESET_PC;
      exp_cnt = '0;
      @(negedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: actual=time expired required=bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bundle_t b;
      int dly;
      do_reset();

      // ALU write-back, sequential PC
      b = mk(32'h8000_0000, 32'h0000_0040, 32'h12, 2'd0, 1'b1, 5'd5);
      send(b, -1, '0, 1'b1);
      // Load after four wait cycles
      b = mk(32'h8000_0004, 32'h0, 32'h1000, 2'd1, 1'b1, 5'd3);
      send(b, 4, 32'hDEAD_BEEF, 1'b1);
      // beq taken and not taken, no register write
      b = mk(32'h8000_0010, 32'hFFFF_FFF8, 32'h0, 2'd0, 1'b0, 5'd0);
      b.branch = 1'b1; b.zero = 1'b1;
      send(b, -1, '0, 1'b1);
      b.zero = 1'b0;
      send(b, -1, '0, 1'b1);
      // jalr: link value and low bit cleared target
      b = mk(32'h8000_0020, 32'h0, 32'h8000_0103, 2'd2, 1'b1, 5'd1);
      b.pcx1 = 1'b1; b.jal = 1'b1;
      send(b, -1, '0, 1'b1);
      // Write to x0 suppressed but still retires
      b = mk(32'h8000_0030, 32'h0, 32'h55, 2'd0, 1'b1, 5'd0);
      send(b, -1, '0, 1'b1);
      // Wrap-around of PC+4
      b = mk(32'hFFFF_FFFC, 32'h0, 32'h0, 2'd2, 1'b1, 5'd7);
      send(b, -1, '0, 1'b1);
      // jal with PC+imm write-back, blt taken and not taken
      b = mk(32'h8000_0100, 32'h0000_0200, 32'h0, 2'd3, 1'b1, 5'd9);
      b.jal = 1'b1;
      send(b, -1, '0, 1'b1);
      b = mk(32'h8000_0200, 32'hFFFF_FF00, 32'h0, 2'd0, 1'b0, 5'd0);
      b.brlt = 1'b1; b.lt = 1'b1;
      send(b, -1, '0, 1'b1);
      b.lt = 1'b0;
      send(b, -1, '0, 1'b1);
      // Load data on the last allowed wait cycle still commits
      b = mk(32'h8000_0300, 32'h0, 32'h0, 2'd1, 1'b1, 5'd12);
      send(b, 254, 32'hCAFE_F00D, 1'b1);
      chk("err_after_late_data", err, 1'b0);

      // Randomized bundles
      for (int i = 0; i < 150; i++) begin
         b.pc     = $urandom;
         b.imm    = $urandom;
         b.alu    = $urandom;
         b.regs   = 2'($urandom_range(0, 3));
         b.regw   = 1'($urandom_range(0, 1));
         b.jal    = ($urandom_range(0, 4) == 0);
         b.branch = ($urandom_range(0, 2) == 0);
         b.brlt   = ($urandom_range(0, 2) == 0);
         b.pcx1   = ($urandom_range(0, 4) == 0);
         b.zero   = 1'($urandom_range(0, 1));
         b.lt     = 1'($urandom_range(0, 1));
         b.rd     = 5'($urandom_range(0, 31));
         dly      = $urandom_range(0, 6);
         send(b, dly, $urandom, 1'b1);
      end

      // Reset while waiting for load data aborts without a retire
      b = mk(32'h8000_0400, 32'h0, 32'h0, 2'd1, 1'b1, 5'd4);
      send(b, -1, '0, 1'b0);
      repeat (5) @(negedge clk);
      chk("abort_ready", in_ready, 1'b0);
      do_reset();
      @(negedge clk);
      chk("abort_ready_after", in_ready, 1'b1);

      // Load timeout: sticky error, frozen PC, no acceptance
      b = mk(32'h8000_0500, 32'h0, 32'h0, 2'd1, 1'b1, 5'd6);
      send(b, -1, '0, 1'b0);
      repeat (255) @(negedge clk);
      chk("err_before_limit", err, 1'b0);
      @(negedge clk);
      chk("err_at_limit", err, 1'b1);
      in_valid = 1'b1;
      mem_rvalid = 1'b1;
      repeat (10) begin
         @(negedge clk);
         chk("err_ready", in_ready, 1'b0);
         chk("err_sticky", err, 1'b1);
      end
      in_valid = 1'b0;
      mem_rvalid = 1'b0;
      do_reset();
      @(negedge clk);
      chk("post_err_clear", err, 1'b0);

      // One ordinary instruction after recovery
      b = mk(RESET_PC, 32'h0, 32'h77, 2'd0, 1'b1, 5'd2);
      send(b, -1, '0, 1'b1);
      repeat (4) @(negedge clk);
      chk("sb_drain", sbq.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/wbu_commit_stage.md
Name: wbu_commit_stage

Overview:
- Write-back/commit stage directly downstream of the control unit and EXU.
- Accepts one decoded-and-executed instruction bundle per handshake and waits for load data when needed.
- Drives the register-file write port, owns the architectural PC register, and emits one commit pulse per retired instruction.
- Blocks in_ready while busy, which makes the single-issue core multi-cycle.

Parameters:
- RESET_PC, 32'h8000_0000: PC value after reset.
- LOAD_TIMEOUT, 255: maximum WAIT_MEM cycles before the stage enters the sticky error state. Counter width is 8 bits; legal values are 1..255.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  EXU bundle valid
- in_ready  out  1  stage can accept a bundle
- jal  in  1  jal instruction
- branch  in  1  beq instruction
- brlt  in  1  blt instruction
- regS  in  2  write-back select: 0 ALU, 1 load data, 2 PC+4, 3 PC+imm
- RegW  in  1  register write enable
- PCx1  in  1  jalr instruction
- in_pc  in  32  PC of the instruction
- in_imm  in  32  sign-extended immediate
- in_alu_res  in  32  ALU result
- in_zero  in  1  ALU result == 0
- in_lt  in  1  signed rs1 < rs2
- in_rd  in  5  destination register
- mem_rvalid  in  1  load data valid
- mem_rdata  in  32  load data
- rf_wen  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  32  register-file write data
- pc  out  32  architectural PC
- commit_valid  out  1  one-cycle retire pulse
- err  out  1  sticky load-timeout error

Behaviour:
- Reset state: IDLE; pc=RESET_PC; in_ready=1; rf_wen=0; rf_waddr=0; rf_wdata=0; commit_valid=0; err=0; timeout counter=0; bundle registers=0.
- Reset asserted mid-operation aborts the in-flight bundle. There is no write and no commit.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch all bundle inputs.
  - If latched regS==1, go to WAIT_MEM; otherwise go to COMMIT.
  - mem_rvalid is ignored in IDLE.
- FSM WAIT_MEM:
  - in_ready=0; the counter increments each cycle.
  - On mem_rvalid, latch mem_rdata, clear the counter, go to COMMIT.
  - If the counter reaches LOAD_TIMEOUT without mem_rvalid, go to ERR.
  - mem_rvalid arriving in the same cycle the limit is reached wins: go to COMMIT.
- FSM COMMIT (exactly one cycle):
  - in_ready=0; commit_valid=1.
  - rf_wen=RegW&&(rd!=0); rf_waddr=rd.
  - rf_wdata per regS: 0 alu_res, 1 load data, 2 pc_in+4, 3 pc_in+imm.
  - pc takes next_pc at the closing edge; then go to IDLE.
- FSM ERR: err=1, in_ready=0, rf_wen=0, pc frozen. Exit only by reset.
- next_pc priority:
  1. PCx1 -> {alu_res[31:1],1'b0}
  2. jal -> pc_in+imm
  3. branch&&zero -> pc_in+imm
  4. brlt&&lt -> pc_in+imm
  5. otherwise pc_in+4
- Arithmetic: all additions are 32-bit modulo, with wrap-around (32'hFFFF_FFFC+4 = 0).
- Outputs outside COMMIT: rf_wen=0 and commit_valid=0.
- Latency, accept to PC update: non-load 2 cycles (accept edge, COMMIT edge); load = 2 + data wait cycles.
- Back-to-back: minimum spacing between accepts is 2 cycles; in_ready rises the cycle after COMMIT.

Optional Feature:
- Macro: WBU_COMMIT_TRACE_EN.
- Defined: adds outputs commit_pc[31:0] (latched in_pc), commit_next_pc[31:0] and commit_cnt[63:0].
  - commit_cnt resets to 0 and increments on each commit_valid.
  - The pc fields are valid only while commit_valid=1 and hold 0 otherwise.
- Undefined: these ports and their registers are absent. Core behaviour is identical.

Test Plan:
- Reset, then add bundle: in_pc=0x80000000, regS=0, RegW=1, rd=5, alu_res=0x12 -> COMMIT cycle shows rf_wen=1, waddr=5, wdata=0x12; pc=0x80000004 next cycle.
- Load bundle (regS=1, rd=3): mem_rvalid after 4 cycles with rdata=0xDEADBEEF -> in_ready=0 throughout; rf_wdata=0xDEADBEEF in COMMIT; pc=in_pc+4.
- beq pc=0x80000010, imm=-8: zero=1 -> pc=0x80000008; zero=0 -> pc=0x80000014. Neither case writes the register file.
- jalr alu_res=0x80000103, rd=1, regS=2, pc_in=0x80000020 -> rf_wdata=0x80000024, pc=0x80000102.
- Write to rd=0 with RegW=1 -> rf_wen=0, commit_valid=1. Also: pc_in=0xFFFFFFFC non-branch -> pc=0.
- Load with no mem_rvalid for 255 cycles -> err=1, in_ready stays 0. Then rst_n pulse -> pc=0x80000000, err=0. Also: reset asserted during WAIT_MEM -> no commit.
